// File: rtl/eeg_aram_bank_ctrl.sv
// Per-bank activation-RAM controller: routed read addresses drive one single-port
// SRAM bank, read data returns through a credit-limited buffer; fill writes only between sessions.
module eeg_aram_bank_ctrl #(
    parameter int unsigned ADD_AW     = 12,
    parameter int unsigned DAT_DW     = 4,
    parameter int unsigned OBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AARB_ADD_VLD,
    input  logic              AARB_ADD_LST,
    input  logic              AARB_ADD_END,
    output logic              AARB_ADD_RDY,
    input  logic [ADD_AW-1:0] AARB_ADD_ADD,
    output logic              AARB_DAT_VLD,
    output logic              AARB_DAT_LST,
    input  logic              AARB_DAT_RDY,
    output logic [DAT_DW-1:0] AARB_DAT_DAT,
    input  logic              WR_VLD,
    output logic              WR_RDY,
    input  logic [ADD_AW-1:0] WR_ADD,
    input  logic [DAT_DW-1:0] WR_DAT,
    output logic              RAM_CEN,
    output logic              RAM_WEN,
    output logic [ADD_AW-1:0] RAM_ADD,
    output logic [DAT_DW-1:0] RAM_DIN,
    input  logic [DAT_DW-1:0] RAM_DOUT,
    output logic              BUSY
);
    localparam int unsigned   PW       = $clog2(OBUF_DEPTH);
    localparam int unsigned   CW       = $clog2(OBUF_DEPTH + 1);
    localparam logic [CW-1:0] CRED_MAX = CW'(OBUF_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     credit, credit_nxt;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DAT_DW-1:0] buf_dat [OBUF_DEPTH];
    logic              buf_lst [OBUF_DEPTH];
    logic              rd_pend, rd_pend_lst;
    logic              rd_acc, wr_acc, pop, buf_vld;

    assign buf_vld      = (cnt != '0);
    assign AARB_ADD_RDY = (state != DRAIN) && (credit < CRED_MAX) && !(state == IDLE && WR_VLD);
    assign WR_RDY       = (state == IDLE);
    // Handshakes are ignored while rst is high so nothing reaches the SRAM in the reset cycle.
    assign rd_acc       = AARB_ADD_VLD && AARB_ADD_RDY && !rst;
    assign wr_acc       = WR_VLD && WR_RDY && !rst;
    assign pop          = buf_vld && AARB_DAT_RDY;
    assign AARB_DAT_VLD = buf_vld;
    assign AARB_DAT_DAT = buf_vld ? buf_dat[rd_ptr] : '0;
    assign AARB_DAT_LST = buf_vld && buf_lst[rd_ptr];
    assign BUSY         = (state != IDLE);

    always_comb begin
        RAM_CEN = 1'b1;
        RAM_WEN = 1'b1;
        RAM_ADD = '0;
        RAM_DIN = '0;
        if (wr_acc) begin
            RAM_CEN = 1'b0;
            RAM_WEN = 1'b0;
            RAM_ADD = WR_ADD;
            RAM_DIN = WR_DAT;
        end else if (rd_acc) begin
            RAM_CEN = 1'b0;
            RAM_ADD = AARB_ADD_ADD;
        end
    end

    always_comb begin
        credit_nxt = credit;
        if (rd_acc && !pop)
            credit_nxt = credit + CW'(1);
        else if (!rd_acc && pop)
            credit_nxt = credit - CW'(1);

        state_nxt = state;
        case (state)
            IDLE:    if (rd_acc) state_nxt = AARB_ADD_END ? DRAIN : ACTIVE;
            ACTIVE:  if (rd_acc && AARB_ADD_END) state_nxt = DRAIN;
            // Leaves DRAIN on the same edge that pops the final word.
            DRAIN:   if (credit_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            cnt         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rd_pend     <= 1'b0;
            rd_pend_lst <= 1'b0;
        end else begin
            state       <= state_nxt;
            credit      <= credit_nxt;
            rd_pend     <= rd_acc;
            rd_pend_lst <= rd_acc && AARB_ADD_LST;
            if (rd_pend)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (rd_pend && !pop)
                cnt <= cnt + CW'(1);
            else if (!rd_pend && pop)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rd_pend) begin
            buf_dat[wr_ptr] <= RAM_DOUT;
            buf_lst[wr_ptr] <= rd_pend_lst;
        end
    end

    // Credits bound in-flight plus buffered words, so these can only fire on a logic error.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(rd_pend && !pop && cnt == CRED_MAX));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && cnt == '0));
    a_cnt_le_cred:  assert property (@(posedge clk) disable iff (rst) cnt <= credit);

endmodule

// File: tb/tb_eeg_aram_bank_ctrl.sv
// Self-checking bench for eeg_aram_bank_ctrl: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_eeg_aram_bank_ctrl;
    localparam int AW    = 12;
    localparam int DW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          AARB_ADD_VLD = 1'b0, AARB_ADD_LST = 1'b0, AARB_ADD_END = 1'b0, AARB_ADD_RDY;
    logic [AW-1:0] AARB_ADD_ADD = '0;
    logic          AARB_DAT_VLD, AARB_DAT_LST, AARB_DAT_RDY = 1'b0;
    logic [DW-1:0] AARB_DAT_DAT;
    logic          WR_VLD = 1'b0, WR_RDY;
    logic [AW-1:0] WR_ADD = '0;
    logic [DW-1:0] WR_DAT = '0;
    logic          RAM_CEN, RAM_WEN;
    logic [AW-1:0] RAM_ADD;
    logic [DW-1:0] RAM_DIN, RAM_DOUT;
    logic          BUSY;

    eeg_aram_bank_ctrl #(.ADD_AW(AW), .DAT_DW(DW), .OBUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .AARB_ADD_VLD(AARB_ADD_VLD), .AARB_ADD_LST(AARB_ADD_LST), .AARB_ADD_END(AARB_ADD_END),
        .AARB_ADD_RDY(AARB_ADD_RDY), .AARB_ADD_ADD(AARB_ADD_ADD),
        .AARB_DAT_VLD(AARB_DAT_VLD), .AARB_DAT_LST(AARB_DAT_LST), .AARB_DAT_RDY(AARB_DAT_RDY),
        .AARB_DAT_DAT(AARB_DAT_DAT),
        .WR_VLD(WR_VLD), .WR_RDY(WR_RDY), .WR_ADD(WR_ADD), .WR_DAT(WR_DAT),
        .RAM_CEN(RAM_CEN), .RAM_WEN(RAM_WEN), .RAM_ADD(RAM_ADD), .RAM_DIN(RAM_DIN),
        .RAM_DOUT(RAM_DOUT), .BUSY(BUSY)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    // Environment SRAM, 1-cycle read latency.
    logic [DW-1:0] sram [1<<AW];
    always @(posedge clk)
        if (!RAM_CEN) begin
            if (!RAM_WEN) sram[RAM_ADD] <= RAM_DIN;
            else          RAM_DOUT      <= sram[RAM_ADD];
        end

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic to_fail(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s at cycle %0d: wait bound expired", nm, cyc);
    endtask

    // Reference model: words in flight and in the buffer as queues, session as two flags.
    typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
    beat_t         m_q[$];
    beat_t         m_pend;
    bit            m_pend_v = 0, m_busy = 0, m_end = 0;
    logic [DW-1:0] mmem [1<<AW];

    int   acc_cyc[$], pop_cyc[$], wr_cyc[$];
    logic [DW-1:0] pop_dat[$];
    logic pop_lst[$];
    int   busy_fall = -1;
    bit   prev_busy = 0;

    always @(negedge clk) begin : model
        bit e_ardy, e_wrdy, e_vld, rd, wr, pp;
        int occ;
        if (rst) begin
            m_q.delete();
            m_pend_v = 0;
            m_busy   = 0;
            m_end    = 0;
            prev_busy = 0;
        end else begin
            if (AARB_ADD_VLD && AARB_ADD_RDY) acc_cyc.push_back(cyc);
            if (AARB_DAT_VLD && AARB_DAT_RDY) begin
                pop_cyc.push_back(cyc); pop_dat.push_back(AARB_DAT_DAT); pop_lst.push_back(AARB_DAT_LST);
            end
            if (WR_VLD && WR_RDY) wr_cyc.push_back(cyc);
            if (prev_busy && !BUSY) busy_fall = cyc;
            prev_busy = BUSY;

            occ    = m_q.size() + int'(m_pend_v);
            e_ardy = !m_end && (occ < DEPTH) && !(!m_busy && WR_VLD);
            e_wrdy = !m_busy;
            e_vld  = (m_q.size() != 0);
            rd     = AARB_ADD_VLD && e_ardy;
            wr     = WR_VLD && e_wrdy;
            pp     = e_vld && AARB_DAT_RDY;

            chk("add_rdy", AARB_ADD_RDY, e_ardy);
            chk("wr_rdy",  WR_RDY, e_wrdy);
            chk("dat_vld", AARB_DAT_VLD, e_vld);
            chk("busy",    BUSY, m_busy);
            if (e_vld) begin
                chk("dat_dat", AARB_DAT_DAT, m_q[0].d);
                chk("dat_lst", AARB_DAT_LST, m_q[0].l);
            end
            chk("ram_cen", RAM_CEN, !(rd || wr));
            if (rd || wr) begin
                chk("ram_wen", RAM_WEN, !wr);
                chk("ram_add", RAM_ADD, wr ? WR_ADD : AARB_ADD_ADD);
                if (wr) chk("ram_din", RAM_DIN, WR_DAT);
            end

            if (pp) void'(m_q.pop_front());
            if (m_pend_v) m_q.push_back(m_pend);
            m_pend_v = rd;
            if (rd) m_pend = '{d: mmem[AARB_ADD_ADD], l: AARB_ADD_LST};
            if (wr) mmem[WR_ADD] = WR_DAT;
            if (rd) begin
                m_busy = 1;
                if (AARB_ADD_END) m_end = 1;
            end
            if (m_end && (m_q.size() + int'(m_pend_v)) == 0) begin
                m_busy = 0;
                m_end  = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs;
        acc_cyc.delete(); pop_cyc.delete(); wr_cyc.delete(); pop_dat.delete(); pop_lst.delete();
        busy_fall = -1;
    endtask

    task automatic send_read(input logic [AW-1:0] a, input logic lst, input logic e);
        int t = 0;
        AARB_ADD_VLD = 1'b1; AARB_ADD_ADD = a; AARB_ADD_LST = lst; AARB_ADD_END = e;
        @(negedge clk);
        while (!AARB_ADD_RDY) begin
            if (++t > 200) begin to_fail("add_accept_wait"); break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        AARB_ADD_VLD = 1'b0; AARB_ADD_LST = 1'b0; AARB_ADD_END = 1'b0;
    endtask

    task automatic wait_write;
        int t = 0;
        @(negedge clk);
        while (!WR_RDY) begin
            if (++t > 200) begin to_fail("wr_accept_wait"); break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
        WR_VLD = 1'b0;
    endtask

    task automatic wait_idle;
        int t = 0;
        @(negedge clk);
        while (BUSY || AARB_DAT_VLD) begin
            if (++t > 300) begin to_fail("idle_wait"); break; end
            @(negedge clk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at cycle %0d: simulation did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] t1 [8];
        logic [DW-1:0] t2 [6];
        t1 = '{4'h1, 4'h0, 4'h3, 4'h2, 4'h5, 4'h4, 4'h7, 4'h6};
        t2 = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h7, 4'h6};
        for (int a = 0; a < (1 << AW); a++) begin
            sram[a] = init_val(AW'(a));
            mmem[a] = init_val(AW'(a));
        end

        // Reset state
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_add_rdy", AARB_ADD_RDY, 1);
        chk("rst_dat_vld", AARB_DAT_VLD, 0);
        chk("rst_wr_rdy",  WR_RDY, 1);
        chk("rst_ram_cen", RAM_CEN, 1);
        chk("rst_busy",    BUSY, 0);
        @(posedge clk); #1;

        // Eight back-to-back reads, LST/END on the last
        clear_logs();
        AARB_DAT_RDY = 1'b1;
        for (int i = 0; i < 8; i++) send_read(AW'(12'h010 + i), i == 7, i == 7);
        wait_idle();
        chk("t1_beats", pop_dat.size(), 8);
        chk("t1_latency", pop_cyc[0] - acc_cyc[0], 2);
        chk("t1_b2b", acc_cyc[7] - acc_cyc[0], 7);
        for (int i = 0; i < 8; i++) begin
            chk("t1_data", pop_dat[i], t1[i]);
            chk("t1_lst", pop_lst[i], i == 7);
        end
        chk("t1_busy_fall", busy_fall - pop_cyc[7], 1);

        // Back-pressure: credit limit stops the fifth address
        clear_logs();
        AARB_DAT_RDY = 1'b0;
        fork
            for (int i = 0; i < 6; i++) send_read(AW'(12'h030 + i), i == 5, i == 5);
            begin
                tick(12);
                chk("t2_accepts_stalled", acc_cyc.size(), 4);
                chk("t2_head_vld", AARB_DAT_VLD, 1);
                chk("t2_head_dat", AARB_DAT_DAT, 4'h3);
                tick(3);
                chk("t2_head_stable", AARB_DAT_DAT, 4'h3);
                chk("t2_accepts_still", acc_cyc.size(), 4);
                AARB_DAT_RDY = 1'b1;
            end
        join
        wait_idle();
        chk("t2_beats", pop_dat.size(), 6);
        for (int i = 0; i < 6; i++) chk("t2_data", pop_dat[i], t2[i]);

        // Simultaneous write and read in IDLE: write wins, read sees new data
        clear_logs();
        WR_VLD = 1'b1; WR_ADD = 12'h020; WR_DAT = 4'hA;
        fork
            wait_write();
            send_read(12'h020, 1'b1, 1'b1);
        join
        wait_idle();
        chk("t3_writes", wr_cyc.size(), 1);
        chk("t3_read_after_write", acc_cyc[0] - wr_cyc[0], 1);
        chk("t3_data", pop_dat[0], 4'hA);

        // Write held off through ACTIVE and DRAIN
        clear_logs();
        send_read(12'h040, 1'b0, 1'b0);
        WR_VLD = 1'b1; WR_ADD = 12'h050; WR_DAT = 4'h9;
        send_read(12'h041, 1'b0, 1'b0);
        send_read(12'h042, 1'b1, 1'b1);
        wait_write();
        wait_idle();
        chk("t4_beats", pop_dat.size(), 3);
        chk("t4_wr_after_drain", wr_cyc[0] - pop_cyc[2], 1);
        clear_logs();
        send_read(12'h050, 1'b1, 1'b1);
        wait_idle();
        chk("t4_readback", pop_dat[0], 4'h9);

        // New address during DRAIN waits for the final pop
        clear_logs();
        AARB_DAT_RDY = 1'b0;
        send_read(12'h060, 1'b1, 1'b1);
        fork
            send_read(12'h061, 1'b1, 1'b1);
            begin tick(4); AARB_DAT_RDY = 1'b1; end
        join
        wait_idle();
        chk("t5_beats", pop_dat.size(), 2);
        chk("t5_second_start", acc_cyc[1] - pop_cyc[0], 1);
        chk("t5_data", pop_dat[1], 4'h7);

        // Reset with three words buffered and one in flight
        clear_logs();
        AARB_DAT_RDY = 1'b0;
        for (int i = 0; i < 4; i++) send_read(AW'(12'h070 + i), 1'b0, 1'b0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_dat_vld", AARB_DAT_VLD, 0);
        chk("t6_add_rdy", AARB_ADD_RDY, 1);
        chk("t6_busy", BUSY, 0);
        chk("t6_wr_rdy", WR_RDY, 1);
        @(posedge clk); #1;
        AARB_DAT_RDY = 1'b1;
        tick(6);
        chk("t6_no_stale", pop_dat.size(), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            AARB_ADD_VLD = ($urandom_range(0, 3) != 0);
            AARB_ADD_ADD = AW'($urandom_range(0, (1 << AW) - 1));
            AARB_ADD_LST = ($urandom_range(0, 3) == 0);
            AARB_ADD_END = ($urandom_range(0, 9) == 0);
            AARB_DAT_RDY = ($urandom_range(0, 3) != 0);
            WR_VLD       = ($urandom_range(0, 5) == 0);
            WR_ADD       = AW'($urandom_range(0, (1 << AW) - 1));
            WR_DAT       = DW'($urandom_range(0, (1 << DW) - 1));
            rst          = ($urandom_range(0, 499) == 0);
            tick(1);
        end
        AARB_ADD_VLD = 1'b0; WR_VLD = 1'b0; rst = 1'b0; AARB_DAT_RDY = 1'b1;
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
